// File: rtl/shifter_pkg.sv
// Shared operation encodings for the pipelined barrel shifter.
package shifter_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROL = 2'b11
   } op_t;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Request/result bundle of the pipelined barrel shifter.
// The master modport issues requests and consumes results; the slave modport is the shifter.
interface pipelined_barrel_shifter_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 5
);
   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic [1:0]         in_op;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [TAG_W-1:0]   out_tag;
   logic [1:0]         out_op;

   modport master (
      output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_op
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_op
   );

endinterface

// File: rtl/shift_stage.sv
// One registered level of the barrel shifter: shifts by DIST when its shamt bit is set.
// Op 11 rotates left when SHIFTER_ROTATE_EN is defined, otherwise it behaves as SLL.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 5,
   parameter int unsigned DIST  = 1,
   localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               up_valid,
   output logic               up_ready,
   input  logic [WIDTH-1:0]   up_data,
   input  logic [SHAMT_W-1:0] up_shamt,
   input  op_t                up_op,
   input  logic [TAG_W-1:0]   up_tag,
   input  logic               up_sign,
   output logic               dn_valid,
   input  logic               dn_ready,
   output logic [WIDTH-1:0]   dn_data,
   output logic [SHAMT_W-1:0] dn_shamt,
   output op_t                dn_op,
   output logic [TAG_W-1:0]   dn_tag,
   output logic               dn_sign
);
   localparam int unsigned BIT = $clog2(DIST);

   logic               valid_q;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SHAMT_W-1:0] shamt_q;
   op_t                op_q;
   logic [TAG_W-1:0]   tag_q;
   logic               sign_q;

   // SRA fill uses the operand's original MSB, carried alongside the data.
   always_comb begin
      data_d = up_data;
      if (up_shamt[BIT]) begin
         case (up_op)
            OP_SLL:  data_d = up_data << DIST;
            OP_SRL:  data_d = up_data >> DIST;
            OP_SRA:  data_d = {{DIST{up_sign}}, up_data[WIDTH-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
            OP_ROL:  data_d = {up_data[WIDTH-1-DIST:0], up_data[WIDTH-1:WIDTH-DIST]};
`else
            OP_ROL:  data_d = up_data << DIST;
`endif
            default: data_d = up_data;
         endcase
      end
   end

   assign up_ready = !valid_q || dn_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         shamt_q <= '0;
         op_q    <= OP_SLL;
         tag_q   <= '0;
         sign_q  <= 1'b0;
      end else begin
         if (up_ready) begin
            valid_q <= up_valid;
         end
         if (up_valid && up_ready) begin
            data_q  <= data_d;
            shamt_q <= up_shamt;
            op_q    <= up_op;
            tag_q   <= up_tag;
            sign_q  <= up_sign;
         end
      end
   end

   assign dn_valid = valid_q;
   assign dn_data  = data_q;
   assign dn_shamt = shamt_q;
   assign dn_op    = op_q;
   assign dn_tag   = tag_q;
   assign dn_sign  = sign_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined SLL/SRL/SRA barrel shifter, one register stage per shamt bit, largest first.
// ROL on op 11 is built only when SHIFTER_ROTATE_EN is defined.
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 5
) (
   input logic clock,
   input logic reset,
   pipelined_barrel_shifter_if.slave bus
);
   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   // Index k is the input side of stage k; index SHAMT_W is the output register set.
   logic               valid_p [SHAMT_W+1];
   logic               ready_p [SHAMT_W+1];
   logic [WIDTH-1:0]   data_p  [SHAMT_W+1];
   logic [SHAMT_W-1:0] shamt_p [SHAMT_W+1];
   op_t                op_p    [SHAMT_W+1];
   logic [TAG_W-1:0]   tag_p   [SHAMT_W+1];
   logic               sign_p  [SHAMT_W+1];

   assign valid_p[0] = bus.in_valid;
   assign data_p[0]  = bus.in_data;
   assign shamt_p[0] = bus.in_shamt;
   assign op_p[0]    = op_t'(bus.in_op);
   assign tag_p[0]   = bus.in_tag;
   assign sign_p[0]  = bus.in_data[WIDTH-1];

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .TAG_W (TAG_W),
         .DIST  (1 << (SHAMT_W - 1 - k))
      ) u_stage (
         .clock    (clock),
         .reset    (reset),
         .up_valid (valid_p[k]),
         .up_ready (ready_p[k]),
         .up_data  (data_p[k]),
         .up_shamt (shamt_p[k]),
         .up_op    (op_p[k]),
         .up_tag   (tag_p[k]),
         .up_sign  (sign_p[k]),
         .dn_valid (valid_p[k+1]),
         .dn_ready (ready_p[k+1]),
         .dn_data  (data_p[k+1]),
         .dn_shamt (shamt_p[k+1]),
         .dn_op    (op_p[k+1]),
         .dn_tag   (tag_p[k+1]),
         .dn_sign  (sign_p[k+1])
      );
   end

   assign ready_p[SHAMT_W] = bus.out_ready;
   assign bus.in_ready     = ready_p[0] && !reset;
   assign bus.out_valid    = valid_p[SHAMT_W];
   assign bus.out_data     = data_p[SHAMT_W];
   assign bus.out_tag      = tag_p[SHAMT_W];
   assign bus.out_op       = op_p[SHAMT_W];

   // The last stage's shamt and sign have no consumer.
   logic unused_tail;
   assign unused_tail = ^{shamt_p[SHAMT_W], sign_p[SHAMT_W]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed ops, stall stream, random traffic, reset.
module tb_pipelined_barrel_shifter;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned TAG_W   = 5;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned LAT     = SHAMT_W;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [1:0]       op;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t             sb[$];
   int               n_checks = 0;
   int               n_errors = 0;
   int               n_out    = 0;
   logic             saw_full = 1'b0;
   logic             rand_done = 1'b0;
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data;
   logic [TAG_W-1:0] prev_tag;
   logic [1:0]       prev_op;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d,
                                              input logic [SHAMT_W-1:0] s, input logic [1:0] op);
      int unsigned sh;
      sh = 32'(s);
      case (op)
         2'b00:   return d << sh;
         2'b01:   return d >> sh;
         2'b10:   return WIDTH'($signed(d) >>> sh);
`ifdef SHIFTER_ROTATE_EN
         default: return (d << sh) | (d >> (WIDTH - sh));
`else
         default: return d << sh;
`endif
      endcase
   endfunction

   // Monitor: sampled mid-cycle, so every handshake seen here completes on the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            sb.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", 32'(bus.out_valid), 32'd1);
               check("hold_data", bus.out_data, prev_data);
               check("hold_tag", 32'(bus.out_tag), 32'(prev_tag));
               check("hold_op", 32'(bus.out_op), 32'(prev_op));
            end
            if (!bus.in_ready) begin
               saw_full = 1'b1;
               check("occupancy_when_not_ready", sb.size(), LAT);
            end
            if (bus.out_valid && bus.out_ready) begin
               n_out++;
               if (sb.size() == 0) begin
                  check("result_expected", sb.size(), 1);
               end else begin
                  e = sb.pop_front();
                  check("out_data", bus.out_data, e.data);
                  check("out_tag", 32'(bus.out_tag), 32'(e.tag));
                  check("out_op", 32'(bus.out_op), 32'(e.op));
               end
            end
            if (bus.in_valid && bus.in_ready) begin
               e.tag  = bus.in_tag;
               e.op   = bus.in_op;
               e.data = model(bus.in_data, bus.in_shamt, bus.in_op);
               sb.push_back(e);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_tag   = bus.out_tag;
            prev_op    = bus.out_op;
         end
      end
   end

   // Presents a request and holds it until accepted; returns just after the accepting edge.
   task automatic send(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                       input logic [1:0] op, input logic [TAG_W-1:0] tag);
      logic acc;
      int   t;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_shamt = s;
      bus.in_op    = op;
      bus.in_tag   = tag;
      t = 0;
      do begin
         @(negedge clock);
         acc = bus.in_ready;
         @(posedge clock);
         #1;
         t++;
      end while (!acc && t < 1000);
      if (!acc) check("send_timeout", 32'(acc), 32'd1);
   endtask

   task automatic directed(input string name, input logic [WIDTH-1:0] d,
                           input logic [SHAMT_W-1:0] s, input logic [1:0] op,
                           input logic [WIDTH-1:0] exp);
      int cyc;
      send(d, s, op, 5'(s));
      bus.in_valid = 1'b0;
      cyc = 1;
      while (!bus.out_valid && cyc < 50) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      check({name, "_latency"}, cyc, LAT);
      check(name, bus.out_data, exp);
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 5000) begin
         @(posedge clock);
         #1;
         t++;
      end
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [WIDTH-1:0] rol_a, rol_b;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_shamt  = '0;
      bus.in_op     = 2'b00;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clock);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_out_tag", 32'(bus.out_tag), 32'd0);
      check("rst_out_op", 32'(bus.out_op), 32'd0);
      reset = 1'b0;
      #1;
      check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

      directed("sll_1_by_31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
      directed("srl_by_4", 32'h8000_0000, 5'd4, 2'b01, 32'h0800_0000);
      directed("sra_neg_by_8", 32'hF000_0000, 5'd8, 2'b10, 32'hFFF0_0000);
      directed("sra_pos_by_8", 32'h7000_0000, 5'd8, 2'b10, 32'h0070_0000);
      directed("sra_by_31", 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
      directed("srl_by_31", 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
      for (int op = 0; op < 4; op++) begin
         directed("shamt0", 32'hDEAD_BEEF, 5'd0, 2'(op), 32'hDEAD_BEEF);
      end
`ifdef SHIFTER_ROTATE_EN
      rol_a = 32'h0000_0003;
      rol_b = 32'h3456_7812;
`else
      rol_a = 32'h0000_0002;
      rol_b = 32'h3456_7800;
`endif
      directed("op11_by_1", 32'h8000_0001, 5'd1, 2'b11, rol_a);
      directed("op11_by_8", 32'h1234_5678, 5'd8, 2'b11, rol_b);

      // Back-to-back stream with the consumer stalled for a window in the middle.
      n0 = n_out;
      saw_full = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               send(32'hA5C3_0F01 ^ (32'(i) << 7), 5'(i * 3), 2'(i), 5'(i));
            end
            bus.in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clock);
            #1;
            bus.out_ready = 1'b0;
            repeat (8) @(posedge clock);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check("stream_count", n_out - n0, 20);
      check("stream_in_ready_dropped", 32'(saw_full), 32'd1);

      // Random valid/ready traffic.
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               bus.in_valid = 1'b0;
               while ($urandom_range(0, 1) == 0) begin
                  @(posedge clock);
                  #1;
               end
               send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(i));
            end
            bus.in_valid = 1'b0;
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clock);
               #1;
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.out_ready = 1'b1;
      drain();
      check("random_count", n_out - n0, 10000);

      // Reset with three requests in flight.
      for (int i = 0; i < 3; i++) begin
         send(32'hFFFF_0000 + 32'(i), 5'(i + 1), 2'b00, 5'(20 + i));
      end
      bus.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("in_ready_during_rst", 32'(bus.in_ready), 32'd0);
      @(posedge clock);
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_out_data", bus.out_data, 32'd0);
      reset = 1'b0;
      #1;
      check("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
      n0 = n_out;
      repeat (10) @(posedge clock);
      #1;
      check("no_stale_results", n_out - n0, 0);
      directed("post_rst_sll", 32'h0000_00FF, 5'd4, 2'b00, 32'h0000_0FF0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
